edge_pulse_gen: RTL and testbench

Transmit-side counterpart of the board's rising-edge detectors. It converts single-cycle request pulses from control logic into clean, well-spaced level transitions on `x_out`. Every accepted request produces exactly one high interval of fixed length followed by a guaranteed low gap, so a downstream rising-edge detector reports exactly one event per request. Requests that arrive while an interval is in progress are queued in a saturating pending counter, and queue overflow is flagged.

---
 rtl/edge_pkg.sv | 32 +++
 rtl/edge_pend_ctr.sv | 54 +++++
 rtl/edge_pulse_gen.sv | 140 ++++++++++++++
 tb/tb_edge_pulse_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge pulse generator: FSM encoding,
// default timing and width helpers.
package edge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_t;

    localparam int DEF_HIGH_CYC = 2;
    localparam int DEF_LOW_CYC  = 1;
    localparam int DEF_MAX_PEND = 7;

    // The unused code 2'b11 falls back to IDLE so a corrupted state self-recovers.
    function automatic state_t decode_state(input logic [1:0] code);
        state_t st;
        case (code)
            2'b01:   st = HIGH;
            2'b10:   st = LOW;
            default: st = IDLE;
        endcase
        return st;
    endfunction

    function automatic int tmr_width(input int high_cyc, input int low_cyc);
        int m;
        m = (high_cyc > low_cyc) ? high_cyc : low_cyc;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/edge_pend_ctr.sv
// Saturating pending-request counter; a request that cannot be queued
// produces a one-cycle ovf pulse on the following cycle.
module edge_pend_ctr
    import edge_pkg::*;
#(
    parameter int MAX_PEND = DEF_MAX_PEND,
    localparam int CW = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          ovf
);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_PEND);

    logic [CW-1:0] cnt_r;
    logic          ovf_r;

    // Count update; simultaneous inc and dec cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= 1'b0;
            case ({inc, dec})
                2'b01: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                2'b10: begin
                    if (cnt_r < CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        ovf_r <= 1'b1;
                    end
                end
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign cnt = cnt_r;
    assign ovf = ovf_r;

endmodule

// File: rtl/edge_pulse_gen.sv
// Turns single-cycle requests into fixed-length high intervals on x_out, each
// followed by a guaranteed low gap; excess requests are queued.
module edge_pulse_gen
    import edge_pkg::*;
#(
    parameter int HIGH_CYC = DEF_HIGH_CYC,
    parameter int LOW_CYC  = DEF_LOW_CYC,
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    output logic          x_out,
    output logic          busy,
    output logic [CW-1:0] pend,
    output logic          ovf
);

    localparam int TW = tmr_width(HIGH_CYC, LOW_CYC);
    localparam logic [TW-1:0] TMR_ZERO  = TW'(0);
    localparam logic [TW-1:0] TMR_ONE   = TW'(1);
    localparam logic [TW-1:0] HIGH_LD   = TW'(HIGH_CYC - 1);
    localparam logic [TW-1:0] LOW_LD    = TW'(LOW_CYC - 1);
    localparam logic [CW-1:0] PEND_ZERO = CW'(0);

    if (HIGH_CYC < 1) begin : g_chk_high
        $error("edge_pulse_gen: HIGH_CYC must be >= 1");
    end
    if (LOW_CYC < 1) begin : g_chk_low
        $error("edge_pulse_gen: LOW_CYC must be >= 1");
    end
    if (MAX_PEND < 1) begin : g_chk_pend
        $error("edge_pulse_gen: MAX_PEND must be >= 1");
    end
    if (CW != $clog2(MAX_PEND + 1)) begin : g_chk_cw
        $error("edge_pulse_gen: CW is derived from MAX_PEND");
    end

    state_t        state_r;
    state_t        state_dec_s;
    logic [TW-1:0] tmr_r;
    logic          x_out_r;
    logic          busy_r;
    logic          start_s;
    logic          consume_s;
    logic [CW-1:0] pend_s;
    logic          ovf_s;

    edge_pend_ctr #(
        .MAX_PEND(MAX_PEND)
    ) u_pend_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (req),
        .dec  (consume_s),
        .cnt  (pend_s),
        .ovf  (ovf_s)
    );

    // Start/consume decode: a fresh request or a queued one may begin a pulse.
    always_comb begin
        state_dec_s = decode_state(state_r);
        start_s     = req || (pend_s != PEND_ZERO);
        consume_s   = 1'b0;
        case (state_dec_s)
            IDLE:    consume_s = start_s;
            LOW:     consume_s = start_s && (tmr_r == TMR_ZERO);
            default: consume_s = 1'b0;
        endcase
    end

    // Pulse FSM with registered x_out/busy reflecting the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            tmr_r   <= TMR_ZERO;
            x_out_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            case (state_dec_s)
                IDLE: begin
                    if (start_s) begin
                        state_r <= HIGH;
                        tmr_r   <= HIGH_LD;
                        x_out_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        tmr_r   <= TMR_ZERO;
                        x_out_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                HIGH: begin
                    busy_r <= 1'b1;
                    if (tmr_r != TMR_ZERO) begin
                        state_r <= HIGH;
                        tmr_r   <= tmr_r - TMR_ONE;
                        x_out_r <= 1'b1;
                    end else begin
                        state_r <= LOW;
                        tmr_r   <= LOW_LD;
                        x_out_r <= 1'b0;
                    end
                end
                LOW: begin
                    if (tmr_r != TMR_ZERO) begin
                        state_r <= LOW;
                        tmr_r   <= tmr_r - TMR_ONE;
                        x_out_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (start_s) begin
                        state_r <= HIGH;
                        tmr_r   <= HIGH_LD;
                        x_out_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        tmr_r   <= TMR_ZERO;
                        x_out_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tmr_r   <= TMR_ZERO;
                    x_out_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out = x_out_r;
    assign busy  = busy_r;
    assign pend  = pend_s;
    assign ovf   = ovf_s;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Scenario bench for edge_pulse_gen: three instances (defaults, MAX_PEND=2,
// HIGH_CYC=4/LOW_CYC=3) checked cycle by cycle against hand-derived waveforms.
module tb_edge_pulse_gen;

    typedef struct packed {
        logic       x;
        logic       busy;
        logic [2:0] pend;
        logic       ovf;
    } exp_t;

    logic       clk;
    logic       rst_a_n, req_a, x_a, busy_a, ovf_a;
    logic [2:0] pend_a;
    logic       rst_b_n, req_b, x_b, busy_b, ovf_b;
    logic [1:0] pend_b;
    logic       rst_c_n, req_c, x_c, busy_c, ovf_c;
    logic [2:0] pend_c;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    edge_pulse_gen u_dut_a (
        .clk(clk), .rst_n(rst_a_n), .req(req_a),
        .x_out(x_a), .busy(busy_a), .pend(pend_a), .ovf(ovf_a)
    );

    edge_pulse_gen #(.MAX_PEND(2)) u_dut_b (
        .clk(clk), .rst_n(rst_b_n), .req(req_b),
        .x_out(x_b), .busy(busy_b), .pend(pend_b), .ovf(ovf_b)
    );

    edge_pulse_gen #(.HIGH_CYC(4), .LOW_CYC(3)) u_dut_c (
        .clk(clk), .rst_n(rst_c_n), .req(req_c),
        .x_out(x_c), .busy(busy_c), .pend(pend_c), .ovf(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        exp_t e, o;
        rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        @(posedge clk); #1;
        e = '0;
        sb_q.push_back(e); sb_q.push_back(e); sb_q.push_back(e);
        @(posedge clk); #1;
        rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            e = sb_q.pop_front();
            if (k == 0)      o = {x_a, busy_a, pend_a, ovf_a};
            else if (k == 1) o = {x_b, busy_b, 1'b0, pend_b, ovf_b};
            else             o = {x_c, busy_c, pend_c, ovf_c};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset dut=%0d got x=%b busy=%b pend=%0d ovf=%b want all zero",
                         k, o.x, o.busy, o.pend, o.ovf);
            end
        end
    endtask

    task automatic test_single();
        logic [0:5] rq, xs, bs;
        exp_t e, o;
        rq = 6'b100000; xs = 6'b110000; bs = 6'b111000;
        for (int i = 0; i < 6; i++) begin
            req_a = rq[i];
            e = '{x: xs[i], busy: bs[i], pend: 3'd0, ovf: 1'b0};
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {x_a, busy_a, pend_a, ovf_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single cyc=%0d got x=%b busy=%b pend=%0d ovf=%b want x=%b busy=%b pend=%0d ovf=%b",
                         i, o.x, o.busy, o.pend, o.ovf, e.x, e.busy, e.pend, e.ovf);
            end
        end
        req_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [0:9] rq, xs, bs;
        int ps [0:9];
        exp_t e, o;
        rq = 10'b1110000000; xs = 10'b1101101100; bs = 10'b1111111110;
        ps = '{0, 1, 2, 1, 1, 1, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            req_a = rq[i];
            e = '{x: xs[i], busy: bs[i], pend: 3'(ps[i]), ovf: 1'b0};
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {x_a, busy_a, pend_a, ovf_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL burst cyc=%0d got x=%b busy=%b pend=%0d ovf=%b want x=%b busy=%b pend=%0d ovf=%b",
                         i, o.x, o.busy, o.pend, o.ovf, e.x, e.busy, e.pend, e.ovf);
            end
        end
        req_a = 1'b0;
    endtask

    // Six requests from IDLE with MAX_PEND=2: two served directly, two queued, two dropped.
    task automatic test_overflow();
        logic [0:14] rq, xs, bs, os;
        int ps [0:14];
        exp_t e, o;
        rq = 15'b111111000000000; xs = 15'b110110110110000;
        bs = 15'b111111111111000; os = 15'b000011000000000;
        ps = '{0, 1, 2, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 15; i++) begin
            req_b = rq[i];
            e = '{x: xs[i], busy: bs[i], pend: 3'(ps[i]), ovf: os[i]};
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {x_b, busy_b, 1'b0, pend_b, ovf_b};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL overflow cyc=%0d got x=%b busy=%b pend=%0d ovf=%b want x=%b busy=%b pend=%0d ovf=%b",
                         i, o.x, o.busy, o.pend, o.ovf, e.x, e.busy, e.pend, e.ovf);
            end
        end
        req_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [0:9] rq, rs, xs, bs;
        int ps [0:9];
        exp_t e, o;
        rq = 10'b1111100000; rs = 10'b1111101111;
        xs = 10'b1101100000; bs = 10'b1111100000;
        ps = '{0, 1, 2, 2, 3, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            req_a = rq[i];
            rst_a_n = rs[i];
            e = '{x: xs[i], busy: bs[i], pend: 3'(ps[i]), ovf: 1'b0};
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {x_a, busy_a, pend_a, ovf_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got x=%b busy=%b pend=%0d ovf=%b want x=%b busy=%b pend=%0d ovf=%b",
                         i, o.x, o.busy, o.pend, o.ovf, e.x, e.busy, e.pend, e.ovf);
            end
        end
        req_a = 1'b0;
        rst_a_n = 1'b1;
    endtask

    task automatic test_long_timing();
        logic [0:15] rq, xs, bs;
        int ps [0:15];
        exp_t e, o;
        rq = 16'b1100000000000000; xs = 16'b1111000111100000;
        bs = 16'b1111111111111100;
        ps = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            req_c = rq[i];
            e = '{x: xs[i], busy: bs[i], pend: 3'(ps[i]), ovf: 1'b0};
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {x_c, busy_c, pend_c, ovf_c};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL long cyc=%0d got x=%b busy=%b pend=%0d ovf=%b want x=%b busy=%b pend=%0d ovf=%b",
                         i, o.x, o.busy, o.pend, o.ovf, e.x, e.busy, e.pend, e.ovf);
            end
        end
        req_c = 1'b0;
    endtask

    task automatic test_reset_priority();
        logic [0:3] rq, rs;
        exp_t e, o;
        rq = 4'b1000; rs = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            req_a = rq[i];
            rst_a_n = rs[i];
            e = '0;
            sb_q.push_back(e);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            o = {x_a, busy_a, pend_a, ovf_a};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL rst_prio cyc=%0d got x=%b busy=%b pend=%0d ovf=%b want all zero",
                         i, o.x, o.busy, o.pend, o.ovf);
            end
        end
        req_a = 1'b0;
        rst_a_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_long_timing();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
